// File: rtl/test_value_uart_tx.sv
// Streams the 16-bit test value over a UART line as four uppercase hex digits plus CR LF,
// whenever the value differs from the last one sent (and once unconditionally after reset).
module test_value_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] test_value,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT          state_q, state_d;
  logic [15:0]    shadow_q, shadow_d;
  logic           force_q, force_d;
  logic [2:0]     byteIdx_q, byteIdx_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [CW-1:0]  baudCnt_q, baudCnt_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           frameDone_q, frameDone_d;
  logic [7:0]     curByte;
  logic           baudLast;

  function automatic logic [7:0] hexAscii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] frameByte(input logic [2:0] idx, input logic [15:0] val);
    case (idx)
      3'd0:    return hexAscii(val[15:12]);
      3'd1:    return hexAscii(val[11:8]);
      3'd2:    return hexAscii(val[7:4]);
      3'd3:    return hexAscii(val[3:0]);
      3'd4:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign baudLast = (baudCnt_q == BAUD_LAST);

  // Outputs are registered from the next-state values so the line never glitches.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    force_d     = force_q;
    byteIdx_d   = byteIdx_q;
    bitIdx_d    = bitIdx_q;
    baudCnt_d   = baudCnt_q;
    tx_d        = 1'b1;
    busy_d      = 1'b0;
    frameDone_d = 1'b0;
    curByte     = 8'h00;

    case (state_q)
      IDLE: begin
        if (force_q || (test_value != shadow_q)) begin
          shadow_d  = test_value;
          force_d   = 1'b0;
          byteIdx_d = 3'd0;
          bitIdx_d  = 3'd0;
          baudCnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baudLast) begin
          baudCnt_d = '0;
          bitIdx_d  = 3'd0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baudLast) begin
          baudCnt_d = '0;
          if (bitIdx_q == 3'd7) state_d = STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          baudCnt_d = baudCnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baudLast) begin
          baudCnt_d = '0;
          if (byteIdx_q < 3'd5) begin
            byteIdx_d = byteIdx_q + 3'd1;
            state_d   = START;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Shadow only changes on the IDLE->START transition, so shadow_q is stable for DATA.
    curByte     = frameByte(byteIdx_d, shadow_q);
    busy_d      = (state_d != IDLE);
    frameDone_d = (state_d == STOP) && (byteIdx_d == 3'd5) && (baudCnt_d == BAUD_LAST);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = curByte[bitIdx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= 16'h0000;
      force_q     <= 1'b1;
      byteIdx_q   <= 3'd0;
      bitIdx_q    <= 3'd0;
      baudCnt_q   <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      force_q     <= force_d;
      byteIdx_q   <= byteIdx_d;
      bitIdx_q    <= bitIdx_d;
      baudCnt_q   <= baudCnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule
